// File: rtl/pc_select_pred.sv
`timescale 1ns/1ps
// pc_select_pred
// Program-counter register and next-PC selector for the pipelined Y86 core.
// Keeps the predicted PC between cycles. JXX is predicted taken and CALL goes
// to its target. Fetch is redirected when a jump mispredicts (resolved in M)
// or when a RET resolves (in W).
//
// Optional feature: define RAS_STACK_EN to build a return-address stack.
// RET then gets a prediction. Without the stack, every fetched RET stalls F
// until W resolves it.
//
// Ports
//   clock, reset_n           clock and asynchronous active-low reset
//   stall_f                  hold pred_pc and the stack this cycle
//   f_valid/f_icode/f_valC/f_valP   instruction fetched at f_pc
//   m_icode/m_cnd/m_valA     JXX resolution in M
//   w_icode/w_valM/w_ret_pred RET resolution in W (w_ret_pred: prediction piped with it)
//   f_pc                     address fetched this cycle (combinational)
//   pred_pc                  registered prediction
//   f_ras_pred               stack top, piped down with a fetched RET
//   ret_stall                fetched RET has no usable prediction
//   redirect                 f_pc is a correction rather than pred_pc
module pc_select_pred #(
    parameter int                 ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 RAS_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall_f,
    input  logic              f_valid,
    input  logic [3:0]        f_icode,
    input  logic [ADDR_W-1:0] f_valC,
    input  logic [ADDR_W-1:0] f_valP,
    input  logic [3:0]        m_icode,
    input  logic              m_cnd,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic [3:0]        w_icode,
    input  logic [ADDR_W-1:0] w_valM,
    input  logic [ADDR_W-1:0] w_ret_pred,
    output logic [ADDR_W-1:0] f_pc,
    output logic [ADDR_W-1:0] pred_pc,
    output logic [ADDR_W-1:0] f_ras_pred,
    output logic              ret_stall,
    output logic              redirect
);

    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] ICODE_CALL = 4'h8;
    localparam logic [3:0] ICODE_RET  = 4'h9;

    logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
    logic              mispredict;
    logic              ret_fix;
    logic              ras_usable;
    logic [ADDR_W-1:0] ras_top;

`ifdef RAS_STACK_EN
    localparam int PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // ras_ptr_q points at the next free slot, so the top is one below it.
    // The pointer wraps, which lets a push into a full stack overwrite the
    // oldest entry.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic              ras_push, ras_pop;

    assign ras_usable = (ras_cnt_q != '0);
    assign ras_top    = ras_mem[ras_ptr_q - PTR_W'(1)];
    assign f_ras_pred = ras_usable ? ras_top : '0;
    assign ret_stall  = f_valid && (f_icode == ICODE_RET) && !ras_usable;
    assign ret_fix    = (w_icode == ICODE_RET) && (w_valM != w_ret_pred);

    // A redirect clears the stack, so a push or pop in the same cycle is dropped.
    assign ras_push = f_valid && !stall_f && (f_icode == ICODE_CALL) && !redirect;
    assign ras_pop  = f_valid && !stall_f && (f_icode == ICODE_RET) && ras_usable && !redirect;

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (redirect) begin
            ras_cnt_d = '0;
        end else if (ras_push) begin
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH))
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
        end else if (ras_pop) begin
            ras_ptr_d = ras_ptr_q - PTR_W'(1);
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    // Stack contents need no reset; the count decides what is valid.
    always_ff @(posedge clock) begin
        if (ras_push)
            ras_mem[ras_ptr_q] <= f_valP;
    end

    logic unused_ret_pred;
    assign unused_ret_pred = 1'b0;
`else
    assign ras_usable = 1'b0;
    assign ras_top    = '0;
    assign f_ras_pred = '0;
    assign ret_stall  = f_valid && (f_icode == ICODE_RET);
    assign ret_fix    = (w_icode == ICODE_RET);

    logic        unused_ret_pred;
    logic [31:0] unused_depth;
    assign unused_ret_pred = ^w_ret_pred;
    assign unused_depth    = RAS_DEPTH;
`endif

    assign mispredict = (m_icode == ICODE_JXX) && !m_cnd;
    assign redirect   = mispredict || ret_fix;

    // Mispredict outranks ret_fix. The two together cannot happen in a real
    // pipeline, because W holds the older instruction.
    always_comb begin
        f_pc = pred_pc_q;
        if (mispredict)
            f_pc = m_valA;
        else if (ret_fix)
            f_pc = w_valM;
    end

    always_comb begin
        pred_pc_d = pred_pc_q;
        if (!stall_f) begin
            case (f_icode)
                ICODE_JXX, ICODE_CALL: pred_pc_d = f_valC;
                ICODE_RET:             pred_pc_d = ras_usable ? ras_top : f_valP;
                default:               pred_pc_d = f_valP;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            pred_pc_q <= RESET_PC;
        else
            pred_pc_q <= pred_pc_d;
    end

    assign pred_pc = pred_pc_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset_n)
            assert (!(mispredict && ret_fix));
    end
`endif

endmodule

// File: tb/tb_pc_select_pred.sv
`timescale 1ns/1ps
module tb_pc_select_pred;

    localparam int          ADDR_W    = 64;
    localparam logic [63:0] RESET_PC  = 64'h0000_0000_0000_1000;
    localparam int          RAS_DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall_f, f_valid, m_cnd;
    logic [3:0]  f_icode, m_icode, w_icode;
    logic [63:0] f_valC, f_valP, m_valA, w_valM, w_ret_pred;
    logic [63:0] f_pc, pred_pc, f_ras_pred;
    logic        ret_stall, redirect;

    pc_select_pred #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .stall_f(stall_f),
        .f_valid(f_valid), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .m_icode(m_icode), .m_cnd(m_cnd), .m_valA(m_valA),
        .w_icode(w_icode), .w_valM(w_valM), .w_ret_pred(w_ret_pred),
        .f_pc(f_pc), .pred_pc(pred_pc), .f_ras_pred(f_ras_pred),
        .ret_stall(ret_stall), .redirect(redirect)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] f_pc;
        logic [63:0] pred_pc;
        logic [63:0] f_ras_pred;
        logic        ret_stall;
        logic        redirect;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference state: the predicted PC and the return stack as a queue
    // (back = top).
    logic [63:0] mdl_pred;
    logic [63:0] mdl_stack[$];

    function automatic logic mdl_ret_fix();
`ifdef RAS_STACK_EN
        return (w_icode == 4'h9) && (w_valM != w_ret_pred);
`else
        return (w_icode == 4'h9);
`endif
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        logic mis;
        mis = (m_icode == 4'h7) && !m_cnd;
        e.pred_pc = mdl_pred;
        if (mis)                e.f_pc = m_valA;
        else if (mdl_ret_fix()) e.f_pc = w_valM;
        else                    e.f_pc = mdl_pred;
        e.redirect   = mis || mdl_ret_fix();
        e.f_ras_pred = (mdl_stack.size() > 0) ? mdl_stack[$] : 64'h0;
        e.ret_stall  = f_valid && (f_icode == 4'h9) && (mdl_stack.size() == 0);
        return e;
    endfunction

    task automatic model_edge();
        logic [63:0] nxt;
        logic        redir;
        redir = ((m_icode == 4'h7) && !m_cnd) || mdl_ret_fix();
        if (f_icode == 4'h7 || f_icode == 4'h8) nxt = f_valC;
        else if (f_icode == 4'h9 && mdl_stack.size() > 0) nxt = mdl_stack[$];
        else nxt = f_valP;
        if (!stall_f) mdl_pred = nxt;
`ifdef RAS_STACK_EN
        if (redir) begin
            mdl_stack.delete();
        end else if (f_valid && !stall_f && f_icode == 4'h8) begin
            mdl_stack.push_back(f_valP);
            if (mdl_stack.size() > RAS_DEPTH) void'(mdl_stack.pop_front());
        end else if (f_valid && !stall_f && f_icode == 4'h9 && mdl_stack.size() > 0) begin
            void'(mdl_stack.pop_back());
        end
`else
        if (redir) mdl_stack.delete();
`endif
    endtask

    task automatic set_nop();
        stall_f = 1'b0; f_valid = 1'b0; f_icode = 4'h0; f_valC = 64'h0; f_valP = 64'h0;
        m_icode = 4'h0; m_cnd = 1'b0; m_valA = 64'h0;
        w_icode = 4'h0; w_valM = 64'h0; w_ret_pred = 64'h0;
    endtask

    task automatic cycle();
        exp_q.push_back(expect_now());
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] valc, input logic [63:0] valp);
        set_nop();
        f_valid = 1'b1; f_icode = ic; f_valC = valc; f_valP = valp;
        cycle();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn %0d: got %h, required %h", name, txn, act, req);
        end
    endtask

    // Monitor: every cycle's outputs are compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("f_pc", f_pc, e.f_pc);
                chk("pred_pc", pred_pc, e.pred_pc);
                chk("f_ras_pred", f_ras_pred, e.f_ras_pred);
                chk("ret_stall", {63'b0, ret_stall}, {63'b0, e.ret_stall});
                chk("redirect", {63'b0, redirect}, {63'b0, e.redirect});
                $display("txn %0d f_pc=%h pred_pc=%h ras=%h ret_stall=%0b redirect=%0b",
                         txn, f_pc, pred_pc, f_ras_pred, ret_stall, redirect);
                txn++;
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        set_nop();
        mdl_pred = RESET_PC;
        exp_q.push_back(expect_now());
        @(posedge clock);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // JXX predicted taken, then a mispredict in M.
        fetch(4'h7, 64'h40, 64'h22);
        set_nop();
        f_valid = 1'b1; f_icode = 4'h0; f_valP = 64'h41;
        m_icode = 4'h7; m_cnd = 1'b0; m_valA = 64'h1A;
        cycle();

        // CALL held by two stall cycles.
        set_nop();
        f_valid = 1'b1; f_icode = 4'h8; f_valC = 64'h100; f_valP = 64'h50;
        stall_f = 1'b1;
        cycle();
        cycle();
        stall_f = 1'b0;
        cycle();
        set_nop();
        cycle();

        // RET fetched, then resolved in W.
        fetch(4'h9, 64'h0, 64'h77);
        set_nop();
        w_icode = 4'h9; w_valM = 64'h2C; w_ret_pred = 64'h0;
        cycle();

        // CALL/RET pair, then a RET resolved in W that agrees with its prediction.
        fetch(4'h8, 64'h200, 64'h13);
        fetch(4'h9, 64'h0, 64'h300);
        set_nop();
        w_icode = 4'h9; w_valM = 64'h13; w_ret_pred = 64'h13;
        cycle();

        // Three nested CALLs into a two-entry stack, then three RETs.
        fetch(4'h8, 64'h400, 64'hA);
        fetch(4'h8, 64'h500, 64'hB);
        fetch(4'h8, 64'h600, 64'hC);
        fetch(4'h9, 64'h0, 64'h700);
        fetch(4'h9, 64'h0, 64'h701);
        fetch(4'h9, 64'h0, 64'h702);

        // Asynchronous reset asserted mid-cycle.
        fetch(4'h8, 64'h999, 64'h55);
        set_nop();
        #2 reset_n = 1'b0;
        mdl_pred = RESET_PC;
        mdl_stack.delete();
        exp_q.push_back(expect_now());
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            stall_f    = ($urandom_range(0, 3) == 0);
            f_valid    = ($urandom_range(0, 7) != 0);
            f_icode    = 4'($urandom_range(0, 11));
            f_valC     = {$urandom, $urandom};
            f_valP     = {$urandom, $urandom};
            m_icode    = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            m_cnd      = 1'($urandom_range(0, 1));
            m_valA     = {$urandom, $urandom};
            w_icode    = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
            w_valM     = {$urandom, $urandom};
            w_ret_pred = ($urandom_range(0, 1) == 1) ? w_valM : {$urandom, $urandom};
            if (m_icode == 4'h7 && !m_cnd && w_icode == 4'h9) w_icode = 4'h0;
            cycle();
        end
        set_nop();

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
